reservation_station: RTL and testbench
======================================

# reservation_station

ALU reservation station for the Tomasulo back end: sits directly downstream of the issue stage and upstream of the integer ALU. It buffers up to DEPTH issued instructions and snoops the CDB for missing operands. Each cycle it dispatches one operand-ready entry to the ALU through a registered valid/ready output. It drives the full flag that the issue stage stalls on.

## Interface
- DEPTH, 4, number of entries (power of 2, ≥2)
- XLEN, 32, operand width
- TAG_W, 5, ROB tag width
- OP_W, 4, ALU op encoding width

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid_i  in  1  issue stage presents an instruction
- issue_op_i  in  OP_W  ALU operation
- issue_rs1_value_i / issue_rs2_value_i  in  XLEN  operand values (meaningful when rdy)
- issue_rs1_rdy_i / issue_rs2_rdy_i  in  1  operand value valid
- issue_rs1_q_i / issue_rs2_q_i  in  TAG_W  producing ROB tag when not rdy
- issue_dest_i  in  TAG_W  destination ROB tag
- rs_full_o  out  1  all entries busy
- cdb_valid_i  in  1  CDB broadcast valid
- cdb_tag_i  in  TAG_W  broadcast tag
- cdb_value_i  in  XLEN  broadcast value
- flush_i  in  1  squash all entries and the output register
- alu_valid_o  out  1  dispatch valid
- alu_ready_i  in  1  ALU accepts
- alu_op_o  out  OP_W;  alu_a_o, alu_b_o  out  XLEN;  alu_dest_o  out  TAG_W

## Operation
- Entry fields: busy, op, vj, vk, qj, qk, rj, rk, dest.
- Allocate: on issue_valid_i && !rs_full_o && !flush_i, write to the lowest-index free entry. issue_valid_i while full is ignored; the issue stage must not do this.
- Issue-cycle bypass: for each operand with rdy=0, if cdb_valid_i && cdb_tag_i==q in the same cycle, store cdb_value_i and set r=1.
- Snoop: every busy entry with r=0 and q==cdb_tag_i under cdb_valid_i captures the value. Both operands may capture from one broadcast.
- Ready: busy && rj && rk.
- Select (see Configuration) one ready entry when the output register is empty or is being accepted this cycle (alu_valid_o && alu_ready_i).
- The selected entry loads into the output register and its busy bit clears at the same edge.
- Output register holds all fields stable while alu_valid_o && !alu_ready_i.
- Flush: all busy bits, age state and alu_valid_o clear at the next edge. Flush dominates a simultaneous issue, CDB capture and dispatch.
- rs_full_o = AND of busy bits from registered state. A same-cycle dispatch does not lower it.

## Timing
- Reset values: all busy=0, alu_valid_o=0, alu_op_o/alu_a_o/alu_b_o/alu_dest_o=0, rs_full_o=0.
- Issue with both operands ready in cycle N: entry written at end of N, selected in N+1, alu_valid_o=1 in N+2. Minimum latency 2.
- CDB wakeup in cycle M (entry already resident): entry ready in M+1, alu_valid_o in M+2.
- Back-to-back: with alu_ready_i held high, one dispatch per cycle.
- Slot freed by dispatch at end of cycle K: rs_full_o low in K+1.
- Reset asserted mid-operation: all state clears immediately (asynchronous); no output is completed.

## Configuration
- RS_AGE_SELECT_EN defined: oldest-first selection via a DEPTH×DEPTH age matrix.
  - On allocate, row i is set to the current busy vector.
  - Entry i wins if it is ready and no entry marked older in row i is ready.
- Undefined: fixed priority, lowest-index ready entry wins; no age matrix.

## Structure
- Shared package: rs entry struct, ALU op encodings, TAG_W/XLEN defaults, CDB struct (reused from the existing CDB definition).
- Sub-module rs_select: ready vector (plus age matrix when enabled) in, one-hot grant out.

## Test plan
- Reset, then issue op=ADD, a=5, b=7, both rdy, dest=3 → alu_valid_o in cycle N+2 with a=5, b=7, dest=3; rs_full_o=0 throughout.
- Issue with rs1 waiting on q=9, CDB tag 9 value 0x55 in the same cycle → entry ready immediately, dispatches with a=0x55.
- Fill all 4 entries waiting on tag 2 → rs_full_o=1, extra issue ignored; CDB tag 2 → 4 dispatches on consecutive cycles, rs_full_o=0 after the first.
- Hold alu_ready_i=0 for 3 cycles → outputs stable and no entry freed; on release, the next entry follows in the next cycle.
- With RS_AGE_SELECT_EN: issue to entry 1, then entry 0 (after a free), both woken together → entry 1 dispatches first; undefined → entry 0 first.
- flush_i together with an issue and a CDB hit → next cycle all busy=0, alu_valid_o=0, rs_full_o=0.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared types for the ALU reservation station: widths, ALU op codes, CDB and entry payloads.
package reservation_station_pkg;

  localparam int unsigned RS_DEPTH = 4;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned TAG_W    = 5;
  localparam int unsigned OP_W     = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
  } cdb_t;

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic             rj;
    logic             rk;
    logic [TAG_W-1:0] dest;
  } rs_entry_t;

  // A waiting operand is satisfied by a matching broadcast.
  function automatic logic operand_hit(input logic rdy, input logic [TAG_W-1:0] q, input cdb_t cdb);
    return cdb.valid && !rdy && (cdb.tag == q);
  endfunction

endpackage

// File: rtl/reservation_station_rs_select.sv
// One-hot dispatch grant from the ready vector.
// RS_AGE_SELECT_EN: oldest-ready via age matrix; otherwise lowest-index ready wins.
module reservation_station_rs_select
  import reservation_station_pkg::*;
#(
  parameter int unsigned DEPTH = RS_DEPTH
) (
  input  logic [DEPTH-1:0]            ready,
`ifdef RS_AGE_SELECT_EN
  input  logic [DEPTH-1:0][DEPTH-1:0] age,
`endif
  output logic [DEPTH-1:0]            grant
);

`ifdef RS_AGE_SELECT_EN
  // age[i][j] set means entry j is older than entry i.
  always_comb begin : age_select
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = ready[i] && !(|(age[i] & ready));
    end
  end
`else
  always_comb begin : prio_select
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: buffers issued ops, snoops the CDB, dispatches one ready op per cycle.
// Optional macro RS_AGE_SELECT_EN selects oldest-first dispatch instead of lowest-index.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned DEPTH = RS_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid_i,
  input  logic [OP_W-1:0]  issue_op_i,
  input  logic [XLEN-1:0]  issue_rs1_value_i,
  input  logic [XLEN-1:0]  issue_rs2_value_i,
  input  logic             issue_rs1_rdy_i,
  input  logic             issue_rs2_rdy_i,
  input  logic [TAG_W-1:0] issue_rs1_q_i,
  input  logic [TAG_W-1:0] issue_rs2_q_i,
  input  logic [TAG_W-1:0] issue_dest_i,
  output logic             rs_full_o,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [XLEN-1:0]  cdb_value_i,
  input  logic             flush_i,
  output logic             alu_valid_o,
  input  logic             alu_ready_i,
  output logic [OP_W-1:0]  alu_op_o,
  output logic [XLEN-1:0]  alu_a_o,
  output logic [XLEN-1:0]  alu_b_o,
  output logic [TAG_W-1:0] alu_dest_o
);

  rs_entry_t        entries_q [DEPTH];
  rs_entry_t        entries_d [DEPTH];
  rs_entry_t        new_entry;
  rs_entry_t        sel;
  cdb_t             cdb;
  logic [DEPTH-1:0] busy_vec;
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] alloc_oh;
  logic [DEPTH-1:0] grant;
  logic             do_alloc;
  logic             can_dispatch;
  logic             do_dispatch;

  assign cdb = {cdb_valid_i, cdb_tag_i, cdb_value_i};

  always_comb begin : entry_status
    busy_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_vec[i]  = entries_q[i].busy;
      ready_vec[i] = entries_q[i].busy && entries_q[i].rj && entries_q[i].rk;
    end
  end

  assign rs_full_o    = &busy_vec;
  assign do_alloc     = issue_valid_i && !rs_full_o && !flush_i;
  assign can_dispatch = !alu_valid_o || alu_ready_i;
  assign do_dispatch  = can_dispatch && (|grant) && !flush_i;

  // Lowest-index free slot; frees from a same-cycle dispatch are not reused until next cycle.
  always_comb begin : alloc_pick
    logic found;
    alloc_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy_vec[i] && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Incoming entry with same-cycle CDB bypass.
  always_comb begin : build_new_entry
    logic hit_j;
    logic hit_k;
    hit_j          = operand_hit(issue_rs1_rdy_i, issue_rs1_q_i, cdb);
    hit_k          = operand_hit(issue_rs2_rdy_i, issue_rs2_q_i, cdb);
    new_entry      = '0;
    new_entry.busy = 1'b1;
    new_entry.op   = issue_op_i;
    new_entry.vj   = hit_j ? cdb.value : issue_rs1_value_i;
    new_entry.vk   = hit_k ? cdb.value : issue_rs2_value_i;
    new_entry.qj   = issue_rs1_q_i;
    new_entry.qk   = issue_rs2_q_i;
    new_entry.rj   = issue_rs1_rdy_i | hit_j;
    new_entry.rk   = issue_rs2_rdy_i | hit_k;
    new_entry.dest = issue_dest_i;
  end

  always_comb begin : next_entries
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].busy && operand_hit(entries_q[i].rj, entries_q[i].qj, cdb)) begin
        entries_d[i].vj = cdb.value;
        entries_d[i].rj = 1'b1;
      end
      if (entries_q[i].busy && operand_hit(entries_q[i].rk, entries_q[i].qk, cdb)) begin
        entries_d[i].vk = cdb.value;
        entries_d[i].rk = 1'b1;
      end
      if (do_dispatch && grant[i]) entries_d[i].busy = 1'b0;
      if (do_alloc && alloc_oh[i]) entries_d[i] = new_entry;
      if (flush_i) entries_d[i].busy = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : entry_regs
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

`ifdef RS_AGE_SELECT_EN
  logic [DEPTH-1:0][DEPTH-1:0] age_q;
  logic [DEPTH-1:0][DEPTH-1:0] age_d;

  // New entry is younger than every busy entry; clearing its column drops stale "older" marks.
  always_comb begin : next_age
    age_d = age_q;
    if (flush_i) begin
      age_d = '0;
    end else if (do_alloc) begin
      for (int i = 0; i < DEPTH; i++) begin
        age_d[i] = age_q[i] & ~alloc_oh;
        if (alloc_oh[i]) age_d[i] = busy_vec;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : age_regs
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end

  reservation_station_rs_select #(.DEPTH(DEPTH)) u_select (
    .ready (ready_vec),
    .age   (age_q),
    .grant (grant)
  );
`else
  reservation_station_rs_select #(.DEPTH(DEPTH)) u_select (
    .ready (ready_vec),
    .grant (grant)
  );
`endif

  always_comb begin : grant_mux
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel = entries_q[i];
    end
  end

  // Output register: reloads only when empty or being accepted.
  always_ff @(posedge clk or posedge rst) begin : out_regs
    if (rst) begin
      alu_valid_o <= 1'b0;
      alu_op_o    <= '0;
      alu_a_o     <= '0;
      alu_b_o     <= '0;
      alu_dest_o  <= '0;
    end else if (flush_i) begin
      alu_valid_o <= 1'b0;
    end else if (can_dispatch) begin
      alu_valid_o <= |grant;
      if (|grant) begin
        alu_op_o   <= sel.op;
        alu_a_o    <= sel.vj;
        alu_b_o    <= sel.vk;
        alu_dest_o <= sel.dest;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station; expectations hand-derived, order depends on RS_AGE_SELECT_EN.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic             clk;
  logic             rst;
  logic             issue_valid_i;
  logic [OP_W-1:0]  issue_op_i;
  logic [XLEN-1:0]  issue_rs1_value_i;
  logic [XLEN-1:0]  issue_rs2_value_i;
  logic             issue_rs1_rdy_i;
  logic             issue_rs2_rdy_i;
  logic [TAG_W-1:0] issue_rs1_q_i;
  logic [TAG_W-1:0] issue_rs2_q_i;
  logic [TAG_W-1:0] issue_dest_i;
  logic             rs_full_o;
  logic             cdb_valid_i;
  logic [TAG_W-1:0] cdb_tag_i;
  logic [XLEN-1:0]  cdb_value_i;
  logic             flush_i;
  logic             alu_valid_o;
  logic             alu_ready_i;
  logic [OP_W-1:0]  alu_op_o;
  logic [XLEN-1:0]  alu_a_o;
  logic [XLEN-1:0]  alu_b_o;
  logic [TAG_W-1:0] alu_dest_o;

  int checks = 0;
  int errors = 0;

`ifdef RS_AGE_SELECT_EN
  localparam logic [63:0] AGE_FIRST  = 64'd22;
  localparam logic [63:0] AGE_SECOND = 64'd23;
`else
  localparam logic [63:0] AGE_FIRST  = 64'd23;
  localparam logic [63:0] AGE_SECOND = 64'd22;
`endif

  reservation_station dut (
    .clk               (clk),
    .rst               (rst),
    .issue_valid_i     (issue_valid_i),
    .issue_op_i        (issue_op_i),
    .issue_rs1_value_i (issue_rs1_value_i),
    .issue_rs2_value_i (issue_rs2_value_i),
    .issue_rs1_rdy_i   (issue_rs1_rdy_i),
    .issue_rs2_rdy_i   (issue_rs2_rdy_i),
    .issue_rs1_q_i     (issue_rs1_q_i),
    .issue_rs2_q_i     (issue_rs2_q_i),
    .issue_dest_i      (issue_dest_i),
    .rs_full_o         (rs_full_o),
    .cdb_valid_i       (cdb_valid_i),
    .cdb_tag_i         (cdb_tag_i),
    .cdb_value_i       (cdb_value_i),
    .flush_i           (flush_i),
    .alu_valid_o       (alu_valid_o),
    .alu_ready_i       (alu_ready_i),
    .alu_op_o          (alu_op_o),
    .alu_a_o           (alu_a_o),
    .alu_b_o           (alu_b_o),
    .alu_dest_o        (alu_dest_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] v1, input logic r1, input logic [4:0] q1,
                       input logic [31:0] v2, input logic r2, input logic [4:0] q2, input logic [4:0] dest);
    issue_valid_i     = 1'b1;
    issue_op_i        = op;
    issue_rs1_value_i = v1;
    issue_rs1_rdy_i   = r1;
    issue_rs1_q_i     = q1;
    issue_rs2_value_i = v2;
    issue_rs2_rdy_i   = r2;
    issue_rs2_q_i     = q2;
    issue_dest_i      = dest;
  endtask

  task automatic cdb(input logic v, input logic [4:0] tag, input logic [31:0] value);
    cdb_valid_i = v;
    cdb_tag_i   = tag;
    cdb_value_i = value;
  endtask

  task automatic expect_out(input string tag, input logic [4:0] dest, input logic [31:0] a, input logic [31:0] b);
    check({tag, "_valid"}, 64'(alu_valid_o), 64'd1);
    check({tag, "_dest"}, 64'(alu_dest_o), 64'(dest));
    check({tag, "_a"}, 64'(alu_a_o), 64'(a));
    check({tag, "_b"}, 64'(alu_b_o), 64'(b));
  endtask

  initial begin
    rst = 1'b1;
    issue_valid_i = 1'b0;
    issue(4'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    issue_valid_i = 1'b0;
    cdb(1'b0, 5'd0, 32'd0);
    flush_i     = 1'b0;
    alu_ready_i = 1'b1;

    tick();
    tick();
    check("rst_valid", 64'(alu_valid_o), 64'd0);
    check("rst_full", 64'(rs_full_o), 64'd0);
    check("rst_op", 64'(alu_op_o), 64'd0);
    check("rst_a", 64'(alu_a_o), 64'd0);
    check("rst_dest", 64'(alu_dest_o), 64'd0);
    rst = 1'b0;
    tick();

    // Basic ADD, both operands ready: valid two edges later
    issue(4'd0, 32'd5, 1'b1, 5'd0, 32'd7, 1'b1, 5'd0, 5'd3);
    tick();
    issue_valid_i = 1'b0;
    check("add_lat1_valid", 64'(alu_valid_o), 64'd0);
    check("add_lat1_full", 64'(rs_full_o), 64'd0);
    tick();
    expect_out("add", 5'd3, 32'd5, 32'd7);
    check("add_op", 64'(alu_op_o), 64'd0);
    check("add_full", 64'(rs_full_o), 64'd0);
    tick();
    check("add_drained", 64'(alu_valid_o), 64'd0);

    // Issue-cycle CDB bypass on rs1
    issue(4'd1, 32'd0, 1'b0, 5'd9, 32'd2, 1'b1, 5'd0, 5'd4);
    cdb(1'b1, 5'd9, 32'h55);
    tick();
    issue_valid_i = 1'b0;
    cdb(1'b0, 5'd0, 32'd0);
    check("byp_lat1_valid", 64'(alu_valid_o), 64'd0);
    tick();
    expect_out("byp", 5'd4, 32'h55, 32'd2);
    check("byp_op", 64'(alu_op_o), 64'd1);
    tick();
    check("byp_drained", 64'(alu_valid_o), 64'd0);

    // Fill all four entries waiting on tag 2
    for (int i = 0; i < 4; i++) begin
      issue(4'd2, 32'd0, 1'b0, 5'd2, 32'(i), 1'b1, 5'd0, 5'(10 + i));
      tick();
    end
    check("fill_full", 64'(rs_full_o), 64'd1);
    issue(4'd0, 32'd1, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 5'd20);
    tick();
    issue_valid_i = 1'b0;
    check("fill_extra_full", 64'(rs_full_o), 64'd1);
    check("fill_extra_valid", 64'(alu_valid_o), 64'd0);
    cdb(1'b1, 5'd2, 32'h100);
    tick();
    cdb(1'b0, 5'd0, 32'd0);
    check("wake_lat1_valid", 64'(alu_valid_o), 64'd0);
    check("wake_lat1_full", 64'(rs_full_o), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out($sformatf("drain%0d", i), 5'(10 + i), 32'h100, 32'(i));
      check($sformatf("drain%0d_full", i), 64'(rs_full_o), 64'd0);
    end
    tick();
    check("drain_done_valid", 64'(alu_valid_o), 64'd0);

    // Backpressure: output holds, slot of waiting entry stays busy
    alu_ready_i = 1'b0;
    issue(4'd3, 32'd1, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 5'd5);
    tick();
    issue(4'd3, 32'd2, 1'b1, 5'd0, 32'd2, 1'b1, 5'd0, 5'd6);
    tick();
    expect_out("stall_load", 5'd5, 32'd1, 32'd1);
    for (int i = 0; i < 3; i++) begin
      issue(4'd4, 32'd0, 1'b0, 5'd15, 32'd0, 1'b0, 5'd15, 5'(7 + i));
      tick();
      expect_out($sformatf("stall%0d", i), 5'd5, 32'd1, 32'd1);
    end
    issue_valid_i = 1'b0;
    check("stall_full", 64'(rs_full_o), 64'd1);
    alu_ready_i = 1'b1;
    tick();
    expect_out("release", 5'd6, 32'd2, 32'd2);
    check("release_full", 64'(rs_full_o), 64'd0);

    // Flush dominates issue, CDB wakeup and a stalled output
    alu_ready_i = 1'b0;
    flush_i     = 1'b1;
    issue(4'd0, 32'd9, 1'b1, 5'd0, 32'd9, 1'b1, 5'd0, 5'd30);
    cdb(1'b1, 5'd15, 32'h77);
    tick();
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
    cdb(1'b0, 5'd0, 32'd0);
    alu_ready_i   = 1'b1;
    check("flush_valid", 64'(alu_valid_o), 64'd0);
    check("flush_full", 64'(rs_full_o), 64'd0);
    tick();
    tick();
    check("flush_empty_valid", 64'(alu_valid_o), 64'd0);

    // Selection order: entry 1 older than entry 0
    issue(4'd0, 32'd3, 1'b1, 5'd0, 32'd3, 1'b1, 5'd0, 5'd21);
    tick();
    issue(4'd0, 32'd0, 1'b0, 5'd3, 32'd1, 1'b1, 5'd0, 5'd22);
    tick();
    expect_out("age_pre", 5'd21, 32'd3, 32'd3);
    issue(4'd0, 32'd0, 1'b0, 5'd3, 32'd1, 1'b1, 5'd0, 5'd23);
    tick();
    issue_valid_i = 1'b0;
    check("age_idle_valid", 64'(alu_valid_o), 64'd0);
    cdb(1'b1, 5'd3, 32'h33);
    tick();
    cdb(1'b0, 5'd0, 32'd0);
    check("age_wake_valid", 64'(alu_valid_o), 64'd0);
    tick();
    expect_out("age_first", 5'(AGE_FIRST), 32'h33, 32'd1);
    tick();
    expect_out("age_second", 5'(AGE_SECOND), 32'h33, 32'd1);
    tick();
    check("age_done_valid", 64'(alu_valid_o), 64'd0);

    // Asynchronous reset mid-operation
    issue(4'd0, 32'd8, 1'b1, 5'd0, 32'd8, 1'b1, 5'd0, 5'd1);
    tick();
    issue(4'd0, 32'd0, 1'b0, 5'd4, 32'd0, 1'b0, 5'd4, 5'd2);
    tick();
    issue_valid_i = 1'b0;
    expect_out("pre_rst", 5'd1, 32'd8, 32'd8);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(alu_valid_o), 64'd0);
    check("async_rst_a", 64'(alu_a_o), 64'd0);
    tick();
    rst = 1'b0;
    cdb(1'b1, 5'd4, 32'h44);
    tick();
    cdb(1'b0, 5'd0, 32'd0);
    tick();
    check("post_rst_valid", 64'(alu_valid_o), 64'd0);
    check("post_rst_full", 64'(rs_full_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
